// File: rtl/reg_file_rename.sv
// rtl/reg_file_rename.sv - architectural register file with ROB-tag renaming
module reg_file_rename #(
    parameter int ROB_W = 6,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [ROB_W-1:0] issue_rob_idx,
    input  logic [4:0]       rs1_addr,
    output logic             rs1_busy,
    output logic [ROB_W-1:0] rs1_tag,
    output logic [XLEN-1:0]  rs1_val,
    input  logic [4:0]       rs2_addr,
    output logic             rs2_busy,
    output logic [ROB_W-1:0] rs2_tag,
    output logic [XLEN-1:0]  rs2_val,
    input  logic             commit_valid,
    input  logic [4:0]       commit_rd,
    input  logic [ROB_W-1:0] commit_rob_idx,
    input  logic [XLEN-1:0]  commit_value,
    input  logic             flush,
    output logic [5:0]       busy_count
);

    logic [XLEN-1:0]  val_q [32];
    logic [ROB_W-1:0] tag_q [32];
    logic [31:0]      busy_q;
    logic [31:0]      busy_d;
    logic [5:0]       count_d;
    logic             commit_wr;
    logic             issue_wr;

    assign commit_wr = commit_valid && (commit_rd != 5'd0);
    assign issue_wr  = issue_valid && (issue_rd != 5'd0) && !flush;

    // Commit releases a rename only if it is the youngest one; issue then wins over commit.
    always_comb begin
        busy_d = busy_q;
        if (commit_wr && busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_idx))
            busy_d[commit_rd] = 1'b0;
        if (flush)
            busy_d = '0;
        else if (issue_wr)
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < 32; i++)
            count_d = count_d + {5'd0, busy_d[i]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            busy_count <= '0;
            for (int i = 0; i < 32; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy) begin
            busy_q     <= busy_d;
            busy_count <= count_d;
            if (commit_wr)
                val_q[commit_rd] <= commit_value;
            if (issue_wr)
                tag_q[issue_rd] <= issue_rob_idx;
        end
    end

    // Result packs {busy, tag, val}; a matching commit this cycle is forwarded.
    function automatic logic [ROB_W+XLEN:0] lookup(input logic [4:0] a);
        logic [ROB_W+XLEN:0] r;
        r = '0;
        if (a != 5'd0) begin
            if (busy_q[a] && commit_valid && (commit_rd == a) && (commit_rob_idx == tag_q[a]))
                r = {1'b0, tag_q[a], commit_value};
            else
                r = {busy_q[a], tag_q[a], val_q[a]};
        end
        return r;
    endfunction

    assign {rs1_busy, rs1_tag, rs1_val} = lookup(rs1_addr);
    assign {rs2_busy, rs2_tag, rs2_val} = lookup(rs2_addr);

endmodule
